// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field slices and the
// fetch-stage state encoding.
package mips_pkg;

  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] J        = 6'd2;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] ADDI     = 6'd8;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Branch displacement in bytes: sign-extended word offset shifted left by 2.
  function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection for the fetch stage: jump beats a taken branch,
// otherwise fall through to pc_plus4.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  // The opcode field is decoded upstream; only the address fields matter here.
  logic unused_op;
  assign unused_op = ^instr[OP_MSB:OP_LSB];

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], instr[JADDR_W-1:0], 2'b00};
    else if (branch && alu_zero)
      next_pc = pc_plus4 + branch_offset(instr[IMM_W-1:0]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and a req/ready memory
// handshake, with the PC updated only when downstream accepts the IR.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [31:0]      pc_plus4,
  output logic             instr_valid,
  input  logic             instr_accept,
  input  logic             jump,
  input  logic             branch,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] accept_cnt
);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         load_ir;
  logic         take;

  next_pc_logic u_next_pc (
    .instr    (instr),
    .pc_plus4 (pc_plus4),
    .jump     (jump),
    .branch   (branch),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // imem_ready only matters in FETCH and instr_accept only in HOLD.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_ir     = 1'b0;
    take        = 1'b0;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_ir    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_accept) begin
          take       = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr      <= '0;
      pc_plus4   <= '0;
      accept_cnt <= '0;
    end else begin
      if (load_ir) begin
        instr    <= imem_rdata;
        pc_plus4 <= pc + 32'd4;
      end
      if (take) begin
        pc         <= next_pc;
        accept_cnt <= accept_cnt + CNT_W'(1);
      end
    end
  end

  assign imem_addr = pc;
  assign op        = instr[OP_MSB:OP_LSB];

endmodule
